// File: rtl/cmd_rx_multi.sv
// UART command receiver: oversampled 8N1 byte deserialiser feeding a nibble-packet
// parser that loads NUM_FIELDS independent field registers and reports every error.
module cmd_rx_multi #(
    parameter int         CLK_HZ        = 22118400,
    parameter int         BAUD          = 9600,
    parameter int         OVERSAMPLE    = 16,
    parameter int         NUM_FIELDS    = 3,
    parameter int         FIELD_NIBBLES = 6,
    parameter logic [3:0] HDR_TAG       = 4'hC,
    parameter int         TIMEOUT_BITS  = 20
) (
    input  logic                                  clk,
    input  logic                                  reset,
    input  logic                                  rx,
    output logic [NUM_FIELDS*4*FIELD_NIBBLES-1:0] field_data,
    output logic [NUM_FIELDS-1:0]                 field_valid,
    output logic                                  pkt_done,
    output logic                                  pkt_err,
    output logic [1:0]                            err_code,
    output logic [1:0]                            dbg_byte_state,
    output logic                                  dbg_pkt_state
);

    localparam int DIV      = CLK_HZ / (BAUD * OVERSAMPLE);
    localparam int FW       = 4 * FIELD_NIBBLES;
    localparam int MID      = OVERSAMPLE / 2;
    localparam int TO_TICKS = TIMEOUT_BITS * OVERSAMPLE;
    localparam int PW       = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int TW       = $clog2(OVERSAMPLE);
    localparam int TOW      = $clog2(TO_TICKS + 1);
    localparam int NW       = $clog2(FIELD_NIBBLES + 1);
    localparam int IW       = (NUM_FIELDS > 1) ? $clog2(NUM_FIELDS) : 1;

    typedef enum logic [1:0] {B_IDLE, B_START, B_DATA, B_STOP} byte_state_t;
    typedef enum logic {P_IDLE, P_PAYLOAD} pkt_state_t;

    // Line synchroniser, edge detect and sample-tick prescaler
    logic [1:0]    rx_sync;
    logic          rx_s, rx_prev, fall, start_edge, tick;
    logic [PW-1:0] presc;
    byte_state_t   b_state, b_next;

    assign rx_s       = rx_sync[1];
    assign fall       = rx_prev & ~rx_s;
    assign start_edge = fall && (b_state == B_IDLE);
    assign tick       = (presc == PW'(DIV - 1));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rx_sync <= 2'b11;
            rx_prev <= 1'b1;
            presc   <= '0;
        end else begin
            rx_sync <= {rx_sync[0], rx};
            rx_prev <= rx_s;
            if (start_edge || tick) presc <= '0;
            else                    presc <= presc + PW'(1);
        end
    end

    // byte_strobe is a one-cycle valid carrying byte_data; the parser has no
    // back-pressure and always accepts it in that cycle. frame_err is exclusive with it.
    logic [TW-1:0] tick_cnt, tick_nx;
    logic [2:0]    bit_cnt, bit_nx;
    logic [1:0]    votes, votes_nx;
    logic [7:0]    shift, shift_nx, byte_data, data_nx;
    logic          byte_strobe, strobe_nx, frame_err, ferr_nx, maj;

    always_comb begin
        b_next    = b_state;
        tick_nx   = tick_cnt;
        bit_nx    = bit_cnt;
        votes_nx  = votes;
        shift_nx  = shift;
        data_nx   = byte_data;
        strobe_nx = 1'b0;
        ferr_nx   = 1'b0;
        maj       = (votes[0] & votes[1]) | (votes[0] & rx_s) | (votes[1] & rx_s);
        if (b_state == B_IDLE) begin
            if (fall) begin
                b_next  = B_START;
                tick_nx = '0;
            end
        end else if (tick) begin
            tick_nx = (tick_cnt == TW'(OVERSAMPLE - 1)) ? '0 : tick_cnt + TW'(1);
            if (tick_cnt == TW'(MID - 1)) votes_nx[0] = rx_s;
            if (tick_cnt == TW'(MID))     votes_nx[1] = rx_s;
            if (tick_cnt == TW'(MID + 1)) begin
                case (b_state)
                    B_START: if (maj) b_next = B_IDLE;
                    B_DATA:  shift_nx = {maj, shift[7:1]};
                    B_STOP: begin
                        b_next = B_IDLE;
                        if (maj) begin
                            strobe_nx = 1'b1;
                            data_nx   = shift;
                        end else begin
                            ferr_nx = 1'b1;
                        end
                    end
                    default: ;
                endcase
            end
            if (tick_cnt == TW'(OVERSAMPLE - 1)) begin
                case (b_state)
                    B_START: begin
                        b_next = B_DATA;
                        bit_nx = '0;
                    end
                    B_DATA: begin
                        if (bit_cnt == 3'd7) b_next = B_STOP;
                        else                 bit_nx = bit_cnt + 3'd1;
                    end
                    default: ;
                endcase
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            b_state     <= B_IDLE;
            tick_cnt    <= '0;
            bit_cnt     <= '0;
            votes       <= '0;
            shift       <= '0;
            byte_data   <= '0;
            byte_strobe <= 1'b0;
            frame_err   <= 1'b0;
        end else begin
            b_state     <= b_next;
            tick_cnt    <= tick_nx;
            bit_cnt     <= bit_nx;
            votes       <= votes_nx;
            shift       <= shift_nx;
            byte_data   <= data_nx;
            byte_strobe <= strobe_nx;
            frame_err   <= ferr_nx;
        end
    end

    // Packet parser
    pkt_state_t                   p_state, p_next;
    logic [IW-1:0]                idx, idx_nx;
    logic [NW-1:0]                nib_cnt, nib_nx;
    logic [FW-1:0]                shadow, sh_nx, sh_shift;
    logic [TOW-1:0]               idle_cnt, idle_nx;
    logic [NUM_FIELDS*FW-1:0]     fd_nx;
    logic [NUM_FIELDS-1:0]        fv_nx;
    logic                         done_nx, perr_nx, hdr_ok;
    logic [1:0]                   code_nx;
    logic [3:0]                   hi, lo;

    assign hi       = byte_data[7:4];
    assign lo       = byte_data[3:0];
    assign hdr_ok   = (hi == HDR_TAG) && ({28'd0, lo} < NUM_FIELDS);
    assign sh_shift = FW'({shadow, lo});

    always_comb begin
        p_next  = p_state;
        idx_nx  = idx;
        nib_nx  = nib_cnt;
        sh_nx   = shadow;
        idle_nx = idle_cnt;
        fd_nx   = field_data;
        fv_nx   = '0;
        done_nx = 1'b0;
        perr_nx = 1'b0;
        code_nx = err_code;
        if (p_state != P_PAYLOAD || start_edge) idle_nx = '0;
        else if (tick)                          idle_nx = idle_cnt + TOW'(1);
        if (frame_err) begin
            perr_nx = 1'b1;
            code_nx = 2'd0;
            p_next  = P_IDLE;
        end else if (byte_strobe) begin
            idle_nx = '0;
            if (p_state == P_IDLE) begin
                if (hdr_ok) begin
                    p_next = P_PAYLOAD;
                    idx_nx = IW'(lo);
                    nib_nx = '0;
                    sh_nx  = '0;
                end else begin
                    perr_nx = 1'b1;
                    code_nx = 2'd1;
                end
            end else if (hi == 4'd0) begin
                sh_nx = sh_shift;
                if (nib_cnt == NW'(FIELD_NIBBLES - 1)) begin
                    for (int i = 0; i < NUM_FIELDS; i++) begin
                        if (idx == IW'(i)) begin
                            fd_nx[i*FW +: FW] = sh_shift;
                            fv_nx[i]          = 1'b1;
                        end
                    end
                    done_nx = 1'b1;
                    p_next  = P_IDLE;
                end else begin
                    nib_nx = nib_cnt + NW'(1);
                end
            end else begin
                // A header mid-payload restarts on that header so the next packet survives
                perr_nx = 1'b1;
                code_nx = 2'd2;
                if (hdr_ok) begin
                    idx_nx = IW'(lo);
                    nib_nx = '0;
                    sh_nx  = '0;
                end else begin
                    p_next = P_IDLE;
                end
            end
        end else if (p_state == P_PAYLOAD && tick && !start_edge &&
                     idle_cnt == TOW'(TO_TICKS - 1)) begin
            perr_nx = 1'b1;
            code_nx = 2'd3;
            p_next  = P_IDLE;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            p_state     <= P_IDLE;
            idx         <= '0;
            nib_cnt     <= '0;
            shadow      <= '0;
            idle_cnt    <= '0;
            field_data  <= '0;
            field_valid <= '0;
            pkt_done    <= 1'b0;
            pkt_err     <= 1'b0;
            err_code    <= 2'd0;
        end else begin
            p_state     <= p_next;
            idx         <= idx_nx;
            nib_cnt     <= nib_nx;
            shadow      <= sh_nx;
            idle_cnt    <= idle_nx;
            field_data  <= fd_nx;
            field_valid <= fv_nx;
            pkt_done    <= done_nx;
            pkt_err     <= perr_nx;
            err_code    <= code_nx;
        end
    end

    assign dbg_byte_state = b_state;
    assign dbg_pkt_state  = p_state;

endmodule
